// File: rtl/cpu_clk_pkg.sv
// Shared types and default widths for the CPU slow test clock controller.
// Command opcodes and FSM state encodings are shared by the controller and bench.
package cpu_clk_pkg;

  localparam int DEF_DIV_W = 16;
  localparam int DEF_CNT_W = 16;
  localparam int EDGE_W    = 32;

  typedef enum logic [1:0] {
    OP_HALT  = 2'b00,
    OP_RUN   = 2'b01,
    OP_STEP  = 2'b10,
    OP_BURST = 2'b11
  } clk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BURST = 2'b10,
    ST_DRAIN = 2'b11
  } clk_state_e;

endpackage

// File: rtl/cpu_clk_div_core.sv
// Half-period divide counter with a registered phase bit.
// rise/fall flag the clk edge at which the phase will toggle high/low.
module cpu_clk_div_core
  import cpu_clk_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             phase,
  output logic             rise,
  output logic             fall
);

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;
  logic             phase_r;
  logic             tick_s;

  assign tick_s = en & (cnt_r == div);
  assign rise   = tick_s & ~phase_r;
  assign fall   = tick_s & phase_r;
  assign phase  = phase_r;

  // Divide counter and phase register; clr parks the clock low with cnt=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (clr) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (en) begin
      if (tick_s) begin
        cnt_r   <= '0;
        phase_r <= ~phase_r;
      end else begin
        cnt_r   <= cnt_r + DIV_ONE;
      end
    end else begin
      cnt_r   <= cnt_r;
      phase_r <= phase_r;
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/halt/step/burst controller for the CPU slow test clock.
// Owns the command handshake, FSM, burst counter and rising-edge counter.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  div_sel,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              cpu_clk,
  output logic              cpu_ce,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic [EDGE_W-1:0] edge_cnt
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [EDGE_W-1:0] EDGE_ONE = {{(EDGE_W-1){1'b0}}, 1'b1};

  clk_state_e        state_r, state_nxt_s;
  logic [DIV_W-1:0]  div_r, div_nxt_s;
  logic [CNT_W-1:0]  rem_r, rem_nxt_s;
  logic              natural_r, natural_nxt_s;
  logic              done_r, done_nxt_s;
  logic              err_r, err_nxt_s;
  logic              cpu_ce_r;
  logic [EDGE_W-1:0] edge_cnt_r;
  logic              clr_s, en_s, phase_s, rise_s, fall_s;
  logic              accept_s, park_now_s;
  clk_op_e           op_s;

  assign op_s       = clk_op_e'(cmd_op);
  assign cmd_ready  = (state_r != ST_DRAIN);
  assign accept_s   = cmd_valid & cmd_ready;
  assign en_s       = (state_r != ST_IDLE);
  // A HALT landing on the falling toggle already leaves the clock low, so it parks at once.
  assign park_now_s = fall_s | (~phase_s & ~rise_s);

  cpu_clk_div_core #(.DIV_W(DIV_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_s),
    .clr   (clr_s),
    .div   (div_r),
    .phase (phase_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  // Next-state, command decode and completion/error pulse generation.
  always_comb begin
    state_nxt_s   = state_r;
    div_nxt_s     = div_r;
    rem_nxt_s     = rem_r;
    natural_nxt_s = natural_r;
    done_nxt_s    = 1'b0;
    err_nxt_s     = 1'b0;
    clr_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clr_s = 1'b1;
        if (accept_s) begin
          case (op_s)
            OP_RUN: begin
              div_nxt_s   = div_sel;
              state_nxt_s = ST_RUN;
            end
            OP_STEP: begin
              div_nxt_s   = div_sel;
              rem_nxt_s   = CNT_ONE;
              state_nxt_s = ST_BURST;
            end
            OP_BURST: begin
              if (cmd_count != '0) begin
                div_nxt_s   = div_sel;
                rem_nxt_s   = cmd_count;
                state_nxt_s = ST_BURST;
              end else begin
                done_nxt_s  = 1'b1;
              end
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN, ST_BURST: begin
        if ((state_r == ST_BURST) && rise_s) begin
          rem_nxt_s = rem_r - CNT_ONE;
        end else begin
          rem_nxt_s = rem_r;
        end
        if (accept_s && (op_s == OP_HALT)) begin
          if (park_now_s) begin
            state_nxt_s = ST_IDLE;
            clr_s       = 1'b1;
          end else begin
            state_nxt_s   = ST_DRAIN;
            natural_nxt_s = 1'b0;
          end
        end else begin
          err_nxt_s = accept_s;
          if ((state_r == ST_BURST) && rise_s && (rem_r == CNT_ONE)) begin
            state_nxt_s   = ST_DRAIN;
            natural_nxt_s = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
      end
      ST_DRAIN: begin
        if (fall_s) begin
          state_nxt_s = ST_IDLE;
          clr_s       = 1'b1;
          done_nxt_s  = natural_r;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        clr_s       = 1'b1;
      end
    endcase
  end

  // FSM, latched command fields and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      div_r     <= '0;
      rem_r     <= '0;
      natural_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      cpu_ce_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      div_r     <= div_nxt_s;
      rem_r     <= rem_nxt_s;
      natural_r <= natural_nxt_s;
      done_r    <= done_nxt_s;
      err_r     <= err_nxt_s;
      cpu_ce_r  <= rise_s;
    end
  end

  // Free-running count of cpu_clk rising edges; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_r <= '0;
    end else if (rise_s) begin
      edge_cnt_r <= edge_cnt_r + EDGE_ONE;
    end else begin
      edge_cnt_r <= edge_cnt_r;
    end
  end

  assign cpu_clk  = phase_s;
  assign cpu_ce   = cpu_ce_r;
  assign busy     = (state_r != ST_IDLE);
  assign done     = done_r;
  assign cmd_err  = err_r;
  assign edge_cnt = edge_cnt_r;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: a timestamp-based reference model pushes
// per-edge expectations; a monitor pops and compares one cycle later.
module tb_cpu_clk_ctrl;
  import cpu_clk_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] div_sel;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_count;
  logic        cpu_clk, cpu_ce, busy, done, cmd_err;
  logic [31:0] edge_cnt;

  always #5 clk = ~clk;

  cpu_clk_ctrl dut (
    .clk(clk), .rst_n(rst_n), .div_sel(div_sel), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .cpu_clk(cpu_clk), .cpu_ce(cpu_ce), .busy(busy), .done(done),
    .cmd_err(cmd_err), .edge_cnt(edge_cnt)
  );

  typedef struct packed {
    logic        cpu_clk, cpu_ce, busy, done, cmd_err, cmd_ready;
    logic [31:0] edge_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model: the clock is described by its start edge t0 and half-period h.
  localparam int M_IDLE = 0, M_RUN = 1, M_BURST = 2, M_DRAIN = 3;
  int          m_mode, m_e, m_t0, m_h, m_rem;
  bit          m_nat;
  logic [31:0] m_ecnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_e = 0; m_t0 = 0; m_h = 1; m_rem = 0; m_nat = 1'b0; m_ecnt = 32'd0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] op, input logic [15:0] d,
                            input logic [15:0] c);
    exp_t x;
    int   k;
    bit   rise, fall, ph, acc;
    m_e++;
    acc  = v && (m_mode != M_DRAIN);
    rise = 1'b0; fall = 1'b0; ph = 1'b0;
    if (m_mode != M_IDLE) begin
      k    = m_e - m_t0;
      ph   = (((k - 1) / m_h) % 2) == 1;
      rise = (k % (2 * m_h)) == m_h;
      fall = (k % (2 * m_h)) == 0;
    end
    x = '0;
    x.cpu_ce = rise;
    if (rise) m_ecnt = m_ecnt + 32'd1;
    case (m_mode)
      M_IDLE: if (acc) begin
        if (op == 2'b01) begin
          m_mode = M_RUN; m_t0 = m_e; m_h = int'(d) + 1;
        end else if (op == 2'b10) begin
          m_mode = M_BURST; m_t0 = m_e; m_h = int'(d) + 1; m_rem = 1;
        end else if (op == 2'b11) begin
          if (c != 16'd0) begin
            m_mode = M_BURST; m_t0 = m_e; m_h = int'(d) + 1; m_rem = int'(c);
          end else x.done = 1'b1;
        end
      end
      M_RUN, M_BURST: begin
        if (m_mode == M_BURST && rise) m_rem--;
        if (acc && op == 2'b00) begin
          if (fall || (!ph && !rise)) m_mode = M_IDLE;
          else begin m_mode = M_DRAIN; m_nat = 1'b0; end
        end else begin
          if (acc) x.cmd_err = 1'b1;
          if (m_mode == M_BURST && rise && m_rem == 0) begin m_mode = M_DRAIN; m_nat = 1'b1; end
        end
      end
      default: if (fall) begin m_mode = M_IDLE; x.done = m_nat; end
    endcase
    x.cpu_clk   = (m_mode != M_IDLE) && ((((m_e - m_t0) / m_h) % 2) == 1);
    x.busy      = (m_mode != M_IDLE);
    x.cmd_ready = (m_mode != M_DRAIN);
    x.edge_cnt  = m_ecnt;
    sb_q.push_back(x);
  endtask

  // Drives one edge's inputs, records the expectation, then advances to posedge+2.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [15:0] d,
                       input logic [15:0] c);
    cmd_valid = v; cmd_op = op; div_sel = d; cmd_count = c;
    model_step(v, op, d, c);
    @(posedge clk); #2;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 7)), 16'($urandom_range(0, 7)));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_mode != M_IDLE && n < 300) begin idle_cycles(1); n++; end
    if (m_mode != M_IDLE) begin
      checks++; errors++;
      $display("FAIL wait_idle: got mode %0d expected %0d", m_mode, M_IDLE);
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each cycle.
  always begin
    exp_t x;
    @(posedge clk); #1;
    if (mon_en && sb_q.size() > 0) begin
      x = sb_q.pop_front();
      chk("cpu_clk",   32'(cpu_clk),   32'(x.cpu_clk));
      chk("cpu_ce",    32'(cpu_ce),    32'(x.cpu_ce));
      chk("busy",      32'(busy),      32'(x.busy));
      chk("done",      32'(done),      32'(x.done));
      chk("cmd_err",   32'(cmd_err),   32'(x.cmd_err));
      chk("cmd_ready", 32'(cmd_ready), 32'(x.cmd_ready));
      chk("edge_cnt",  edge_cnt,       x.edge_cnt);
    end
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; div_sel = 16'd0; cmd_count = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_clk", 32'(cpu_clk), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_edge_cnt", edge_cnt, 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    idle_cycles(2);

    // RUN at div 2, then HALT.
    cycle(1'b1, 2'b01, 16'd2, 16'd0);
    idle_cycles(20);
    cycle(1'b1, 2'b00, 16'd0, 16'd0);
    wait_idle();
    // STEP at div 0.
    cycle(1'b1, 2'b10, 16'd0, 16'd9);
    wait_idle(); idle_cycles(2);
    // BURST of 5 at div 1.
    cycle(1'b1, 2'b11, 16'd1, 16'd5);
    wait_idle(); idle_cycles(2);
    // BURST of 3, HALT while the first high half is in progress.
    cycle(1'b1, 2'b11, 16'd1, 16'd3);
    idle_cycles(2);
    cycle(1'b1, 2'b00, 16'd0, 16'd0);
    wait_idle(); idle_cycles(2);
    // RUN at div 1, STEP while running, HALT on a rising toggle.
    cycle(1'b1, 2'b01, 16'd1, 16'd0);
    idle_cycles(3);
    cycle(1'b1, 2'b10, 16'd3, 16'd0);
    idle_cycles(1);
    cycle(1'b1, 2'b00, 16'd0, 16'd0);
    wait_idle(); idle_cycles(2);

    // Async reset in the middle of a burst while cpu_clk is high.
    cycle(1'b1, 2'b11, 16'd2, 16'd4);
    idle_cycles(5);
    #1;
    mon_en = 1'b0;
    sb_q.delete();
    rst_n = 1'b0;
    #1;
    chk("arst_cpu_clk", 32'(cpu_clk), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_edge_cnt", edge_cnt, 32'd0);
    chk("arst_cpu_ce", 32'(cpu_ce), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    idle_cycles(2);
    // BURST of zero from IDLE.
    cycle(1'b1, 2'b11, 16'd3, 16'd0);
    idle_cycles(3);

    // Randomized command traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) < 2)
        cycle(1'b1, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 3)), 16'($urandom_range(0, 4)));
      else
        idle_cycles(1);
    end
    cycle(1'b1, 2'b00, 16'd0, 16'd0);
    wait_idle();
    idle_cycles(2);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
